// File: rtl/noc_pkg.sv
// Shared constants for the 3x3-mesh router: port indices, flit types and gate ranges.
package noc_pkg;

    localparam int N_PORTS = 5;
    localparam int GATE_W  = 3;
    localparam int TYPE_W  = 2;

    localparam logic [GATE_W-1:0] P_LOCAL = 3'd0;
    localparam logic [GATE_W-1:0] P_NORTH = 3'd1;
    localparam logic [GATE_W-1:0] P_EAST  = 3'd2;
    localparam logic [GATE_W-1:0] P_SOUTH = 3'd3;
    localparam logic [GATE_W-1:0] P_WEST  = 3'd4;

    // Gate codes at or above this value do not name a port.
    localparam logic [GATE_W-1:0] GATE_ILLEGAL_MIN = 3'd5;
    localparam logic [GATE_W-1:0] GATE_NONE        = 3'b111;

    localparam logic [TYPE_W-1:0] FT_HEAD   = 2'b00;
    localparam logic [TYPE_W-1:0] FT_BODY   = 2'b01;
    localparam logic [TYPE_W-1:0] FT_TAIL   = 2'b10;
    localparam logic [TYPE_W-1:0] FT_SINGLE = 2'b11;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_BUSY = 1'b1
    } out_state_e;

    // HEAD and SINGLE both open a packet and so compete in arbitration.
    function automatic logic is_head(input logic [TYPE_W-1:0] flitType);
        return (flitType == FT_HEAD) || (flitType == FT_SINGLE);
    endfunction

endpackage

// File: rtl/sw_alloc_if.sv
// Request/grant bundle between the RC stages, the allocator and the crossbar.
interface sw_alloc_if;
    import noc_pkg::*;

    logic                       enable;
    logic [N_PORTS-1:0]         req_valid;
    logic [N_PORTS*GATE_W-1:0]  req_gate;
    logic [N_PORTS*TYPE_W-1:0]  req_type;
    logic [N_PORTS-1:0]         out_ready;
    logic [N_PORTS-1:0]         grant;
    logic [N_PORTS-1:0]         out_valid;
    logic [N_PORTS*GATE_W-1:0]  out_sel;
    logic                       err;

    modport master (
        output enable, req_valid, req_gate, req_type, out_ready,
        input  grant, out_valid, out_sel, err
    );

    modport slave (
        input  enable, req_valid, req_gate, req_type, out_ready,
        output grant, out_valid, out_sel, err
    );

endinterface

// File: rtl/rr_arb5.sv
// Five-way round-robin picker: returns the first requester at or after ptr.
module rr_arb5
    import noc_pkg::*;
(
    input  logic [N_PORTS-1:0] req_i,
    input  logic [GATE_W-1:0]  ptr_i,
    output logic               found_o,
    output logic [GATE_W-1:0]  idx_o
);

    always_comb begin
        int j;
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int k = 0; k < N_PORTS; k++) begin
            j = (int'(ptr_i) + k) % N_PORTS;
            if (!found_o && req_i[j]) begin
                found_o = 1'b1;
                idx_o   = GATE_W'(j);
            end
        end
    end

endmodule

// File: rtl/sw_alloc.sv
// Switch allocator: per-output round-robin arbitration with wormhole locking.
module sw_alloc
    import noc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    sw_alloc_if.slave  bus
);

    out_state_e        state_q [N_PORTS];
    out_state_e        state_d [N_PORTS];
    logic [GATE_W-1:0] owner_q [N_PORTS];
    logic [GATE_W-1:0] owner_d [N_PORTS];
    logic [GATE_W-1:0] rrPtr_q [N_PORTS];
    logic [GATE_W-1:0] rrPtr_d [N_PORTS];
    logic              errFlag_q;
    logic              errFlag_d;

    logic [GATE_W-1:0]         reqGate [N_PORTS];
    logic [TYPE_W-1:0]         reqType [N_PORTS];
    logic [N_PORTS-1:0]        headReq [N_PORTS];
    logic                      arbFound [N_PORTS];
    logic [GATE_W-1:0]         arbIdx [N_PORTS];
    logic [N_PORTS-1:0]        grantVec;
    logic [N_PORTS-1:0]        validVec;
    logic [N_PORTS*GATE_W-1:0] selVec;

    // Unpack the flat request buses and build each output's head-candidate mask.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            reqGate[i] = bus.req_gate[i*GATE_W +: GATE_W];
            reqType[i] = bus.req_type[i*TYPE_W +: TYPE_W];
        end
        for (int o = 0; o < N_PORTS; o++) begin
            headReq[o] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                headReq[o][i] = bus.req_valid[i] && (reqGate[i] == GATE_W'(o))
                                && is_head(reqType[i]);
            end
        end
    end

    for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
        rr_arb5 u_arb (
            .req_i   (headReq[o]),
            .ptr_i   (rrPtr_q[o]),
            .found_o (arbFound[o]),
            .idx_o   (arbIdx[o])
        );
    end

    always_comb begin
        logic [GATE_W-1:0] winner;
        logic              granted;
        logic              ownerHit;
        logic              errSet;
        grantVec  = '0;
        validVec  = '0;
        selVec    = '1;
        errSet    = 1'b0;
        winner    = '0;
        granted   = 1'b0;
        ownerHit  = 1'b0;
        for (int o = 0; o < N_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            rrPtr_d[o] = rrPtr_q[o];
            if (state_q[o] == OUT_IDLE) begin
                winner  = arbIdx[o];
                granted = arbFound[o];
            end else begin
                winner   = owner_q[o];
                ownerHit = bus.req_valid[winner] && (reqGate[winner] == GATE_W'(o));
                granted  = ownerHit && !is_head(reqType[winner]);
                if (ownerHit && is_head(reqType[winner])) begin
                    errSet = 1'b1;
                end
            end
            granted = granted && bus.out_ready[o] && bus.enable;
            if (granted) begin
                validVec[o]                   = 1'b1;
                selVec[o*GATE_W +: GATE_W]    = winner;
                grantVec[winner]              = 1'b1;
                if (state_q[o] == OUT_IDLE) begin
                    rrPtr_d[o] = (winner == P_WEST) ? P_LOCAL : winner + 3'd1;
                    if (reqType[winner] == FT_HEAD) begin
                        state_d[o] = OUT_BUSY;
                        owner_d[o] = winner;
                    end
                end else if (reqType[winner] == FT_TAIL) begin
                    state_d[o] = OUT_IDLE;
                end
            end
        end
        // Illegal gates and packet bodies with no open packet are protocol errors.
        for (int i = 0; i < N_PORTS; i++) begin
            if (bus.req_valid[i]) begin
                if (reqGate[i] >= GATE_ILLEGAL_MIN) begin
                    errSet = 1'b1;
                end else if ((state_q[reqGate[i]] == OUT_IDLE) && !is_head(reqType[i])) begin
                    errSet = 1'b1;
                end
            end
        end
        errFlag_d = errFlag_q | (errSet & bus.enable);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < N_PORTS; o++) begin
                state_q[o] <= OUT_IDLE;
                owner_q[o] <= '0;
                rrPtr_q[o] <= '0;
            end
            errFlag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rrPtr_q   <= rrPtr_d;
            errFlag_q <= errFlag_d;
        end
    end

    assign bus.grant     = rst ? '0 : grantVec;
    assign bus.out_valid = rst ? '0 : validVec;
    assign bus.out_sel   = rst ? {N_PORTS{GATE_NONE}} : selVec;
    assign bus.err       = errFlag_q;

endmodule
